tx_uart: RTL and testbench

- UART transmitter, parallel in, serial out. Transmit counterpart of the Rx_top receive path.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1). This is the format check_parity expects.
- Accepts one byte per valid/ready handshake and drives it onto serial_out at CLKS_PER_BIT clocks per bit.
- Sits between the host-side byte source and the pad.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/tx_uart_if.sv | 9 +
 rtl/uart_baud_counter.sv | 26 ++
 rtl/tx_uart.sv | 121 ++++++++++++
 tb/tb_tx_uart.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, frame constants and the
// parity helper. The receive path imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned FRAME_BITS  = 11;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_uart_if.sv
// Host-side byte handshake for the UART transmitter.
interface tx_uart_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. clear holds the count at zero.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit counter, wrapping at each bit boundary.
  always_ff @(posedge clk) begin
    if (reset || clear)       cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/tx_uart.sv
// UART transmitter: 1 start, 8 data (LSB first), even parity, 1 stop.
// Optional macro TX_HOLD_BUFFER_EN adds a one-entry holding register so a
// second byte can be accepted during a frame and sent with no idle gap.
module tx_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  tx_uart_if.slave        tx_if,
  output logic            serial_out,
  output logic            tx_busy,
  output logic            tx_done
);

  uart_state_e    state, state_next;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           parity;
  logic           bit_end;
  logic           handshake;
  logic [7:0]     hold;
  logic           hold_full;
  logic           load_from_hold;

  assign handshake = tx_if.tx_valid && tx_if.tx_ready;

`ifdef TX_HOLD_BUFFER_EN
  assign tx_if.tx_ready = (state == IDLE) || !hold_full;

  // Holding register: a new byte fills it whenever it is not going straight
  // into the shift register; a fill wins over the clear on frame chaining.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (handshake && (state != IDLE || hold_full)) begin
      hold      <= tx_if.tx_data;
      hold_full <= 1'b1;
    end else if (load_from_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign tx_if.tx_ready = (state == IDLE);
  assign hold           = '0;
  assign hold_full      = 1'b0;
`endif

  assign load_from_hold = hold_full && ((state == IDLE) || (state == STOP && bit_end));

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and line/status outputs.
  always_comb begin
    state_next = state;
    serial_out = IDLE_LEVEL;
    tx_busy    = 1'b1;
    tx_done    = 1'b0;
    case (state)
      IDLE: begin
        tx_busy = 1'b0;
        if (handshake || hold_full) state_next = START;
      end
      START: begin
        serial_out = START_LEVEL;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        serial_out = shift[0];
        if (bit_end && bit_idx == 3'(DATA_BITS - 1)) state_next = PARITY;
      end
      PARITY: begin
        serial_out = parity;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        serial_out = STOP_LEVEL;
        tx_done    = bit_end;
        if (bit_end) state_next = hold_full ? START : IDLE;
      end
      default: begin
        tx_busy    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Frame datapath: byte load (from hold or directly), parity, bit shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      parity  <= 1'b0;
      bit_idx <= '0;
    end else if (load_from_hold) begin
      shift   <= hold;
      parity  <= even_parity(hold);
      bit_idx <= '0;
    end else if (state == IDLE && handshake) begin
      shift   <= tx_if.tx_data;
      parity  <= even_parity(tx_if.tx_data);
      bit_idx <= '0;
    end else if (state == DATA && bit_end) begin
      shift   <= {1'b0, shift[7:1]};
      bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: a serial-line monitor decodes every frame and checks it
// against a queue of expected bytes pushed by the stimulus; directed checks
// cover reset, frame timing, back-to-back behaviour and reset mid-frame.
module tb_tx_uart;
  import uart_pkg::*;

  localparam int unsigned CPB       = 16;
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_out, tx_busy, tx_done;

  tx_uart_if u_if ();

  tx_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_if      (u_if),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    @(negedge clk);
    u_if.tx_data  = b;
    u_if.tx_valid = 1'b1;
    while (n < 2000) begin
      if (u_if.tx_ready) begin
        @(posedge clk);
        #1;
        u_if.tx_valid = 1'b0;
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) begin
      u_if.tx_valid = 1'b0;
      tests++;
      fails++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected handshake", b);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d frames outstanding, expected 0", name, sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic mon_wait(input int n, output bit ab);
    ab = 0;
    repeat (n) begin
      @(negedge clk);
      if (reset) ab = 1;
    end
  endtask

  // Monitor: line receiver sampling mid-bit, compares against the scoreboard.
  initial begin : monitor
    logic [9:0] rx;
    logic       st;
    bit         ab, a2;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset && serial_out === 1'b0) begin
        mon_wait(CPB / 2, ab);
        st = serial_out;
        for (int i = 0; i < 10; i++) begin
          mon_wait(CPB, a2);
          ab    = ab | a2;
          rx[i] = serial_out;
        end
        if (!ab) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected_frame: got data 0x%0h, expected no frame", rx[7:0]);
          end else begin
            e = sb.pop_front();
            check("mon_data", 32'(rx[7:0]), 32'(e.data));
            check("mon_parity", 32'(rx[8]), 32'(e.parity));
            check("mon_framing", 32'({st, rx[9]}), 32'd1);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    logic [10:0] f55;
    logic        exp_ser, exp_busy, exp_rdy;
    int          bad_ser, bad_rdy, busy_cnt, done_k, done_cnt;
    int          nhs, ndone, first_low, ready_err, cnt;
    int          hs_n[2];
    int          done_n[2];
    bit          hs;
    logic [7:0]  b;

    u_if.tx_data  = 8'hEE;
    u_if.tx_valid = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial_out", 32'(serial_out), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    u_if.tx_valid = 1'b0;
    reset         = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", 32'(u_if.tx_ready), 32'd1);
    check("rst_valid_ignored", 32'(tx_busy), 32'd0);

    // 0x55 with cycle-exact waveform: {stop, parity, data, start}
    f55 = 11'b1_0_01010101_0;
    sb.push_back('{8'h55, 1'b0});
    send(8'h55);
    bad_ser = 0; bad_rdy = 0; busy_cnt = 0; done_k = 0; done_cnt = 0;
    for (int k = 1; k <= int'(FRAME_CYC) + 1; k++) begin
      @(negedge clk);
      exp_ser = (k <= int'(FRAME_CYC)) ? f55[(k - 1) / int'(CPB)] : 1'b1;
`ifdef TX_HOLD_BUFFER_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = (k > int'(FRAME_CYC));
`endif
      if (serial_out !== exp_ser && bad_ser == 0) bad_ser = k;
      if (u_if.tx_ready !== exp_rdy && bad_rdy == 0) bad_rdy = k;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
    end
    check("w55_serial_first_bad_cycle", 32'(bad_ser), 32'd0);
    check("w55_ready_first_bad_cycle", 32'(bad_rdy), 32'd0);
    check("w55_busy_cycles", 32'(busy_cnt), 32'd176);
    check("w55_done_cycle", 32'(done_k), 32'd176);
    check("w55_done_pulses", 32'(done_cnt), 32'd1);
    wait_idle("w55_drain");

    // Parity corner bytes
    sb.push_back('{8'h07, 1'b1});
    send(8'h07);
    sb.push_back('{8'h00, 1'b0});
    send(8'h00);
    sb.push_back('{8'hFF, 1'b0});
    send(8'hFF);
    wait_idle("parity_drain");

    // Back-to-back with tx_valid held: 0xA5 then 0x3C
    sb.push_back('{8'hA5, 1'b0});
    sb.push_back('{8'h3C, 1'b0});
    nhs = 0; ndone = 0; first_low = -1; ready_err = 0;
    hs_n[0] = 0; hs_n[1] = 0; done_n[0] = 0; done_n[1] = 0;
    @(negedge clk);
    u_if.tx_data  = 8'hA5;
    u_if.tx_valid = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (ndone >= 1 && first_low < 0 && serial_out === 1'b0) first_low = n;
      if (tx_done === 1'b1 && ndone < 2) begin
        done_n[ndone] = n;
        ndone++;
      end
      if (nhs == 1 && ndone == 0 && u_if.tx_ready === 1'b1) ready_err++;
      hs = u_if.tx_valid && u_if.tx_ready;
      @(posedge clk);
      #1;
      if (hs && nhs < 2) begin
        hs_n[nhs] = n;
        nhs++;
        if (nhs == 1) u_if.tx_data  = 8'h3C;
        else          u_if.tx_valid = 1'b0;
      end
      @(negedge clk);
      if (ndone == 2) break;
    end
    u_if.tx_valid = 1'b0;
    check("b2b_handshakes", 32'(nhs), 32'd2);
    check("b2b_done_pulses", 32'(ndone), 32'd2);
`ifdef TX_HOLD_BUFFER_EN
    check("b2b_accept_gap", 32'(hs_n[1] - hs_n[0]), 32'd1);
    check("b2b_idle_gap", 32'(first_low - done_n[0] - 1), 32'd0);
    check("b2b_done_gap", 32'(done_n[1] - done_n[0]), 32'd176);
`else
    check("b2b_ready_low_in_frame", 32'(ready_err), 32'd0);
    check("b2b_accept_gap", 32'(hs_n[1] - hs_n[0]), 32'd177);
    check("b2b_idle_gap", 32'(first_low - done_n[0] - 1), 32'd1);
    check("b2b_done_gap", 32'(done_n[1] - done_n[0]), 32'd177);
`endif
    wait_idle("b2b_drain");

    // tx_data changes during the frame must not leak into it
    sb.push_back('{8'h12, 1'b0});
    send(8'h12);
    u_if.tx_data = 8'hFF;
    wait_idle("hold_data_drain");

    // Reset during data bit 3 of 0xF0 (bit 3 is 0 on the line)
    send(8'hF0);
    repeat (70) @(negedge clk);
    check("midrst_bit3_level", 32'(serial_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_serial_out", 32'(serial_out), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tx_ready", 32'(u_if.tx_ready), 32'd1);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_done === 1'b1) cnt++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    sb.push_back('{8'h81, 1'b0});
    send(8'h81);
    wait_idle("midrst_drain");

    // Random bytes through the line monitor
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      sb.push_back('{b, ^b});
      send(b);
    end
    wait_idle("random_drain");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
